// File: rtl/spu_imm_decode.sv
// SPU decode slice: classifies the immediate format of an instruction word and presents raw
// immediate/register fields through a 2-entry skid stage. IMM_UNSUP_CNT_EN adds a no-match counter.
module spu_imm_decode #(
    parameter int unsigned INSTR_W = 32
`ifdef IMM_UNSUP_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6:0]         imm7,
    output logic [9:0]         imm10,
    output logic [15:0]        imm16,
    output logic [17:0]        imm18,
    output logic [1:0]         imm_sel,
    output logic               has_imm,
    output logic [6:0]         ra,
    output logic [6:0]         rt,
    output logic [10:0]        op11
`ifdef IMM_UNSUP_CNT_EN
    ,
    output logic [CNT_W-1:0]   unsup_cnt
`endif
);

    localparam logic [1:0] SelRi7  = 2'b00;
    localparam logic [1:0] SelRi10 = 2'b01;
    localparam logic [1:0] SelRi16 = 2'b10;
    localparam logic [1:0] SelRi18 = 2'b11;

    logic [1:0]         dec_sel;
    logic               dec_has;

    logic [INSTR_W-1:0] main_instr_q, skid_instr_q;
    logic [1:0]         main_sel_q, skid_sel_q;
    logic               main_has_q, skid_has_q;
    logic               main_valid_q, skid_valid_q;

    logic               in_fire;
    logic               out_fire;

    // Priority order RI18 > RI16 > RI10 > RI7; a miss still flows downstream with has_imm=0.
    always_comb begin
        dec_has = 1'b1;
        dec_sel = SelRi7;
        if (instr[31:25] == 7'h21) begin
            dec_sel = SelRi18;
        end else if (instr[31:23] inside {9'h081, 9'h082, 9'h083, 9'h0C1}) begin
            dec_sel = SelRi16;
        end else if (instr[31:24] inside {8'h1C, 8'h1D, 8'h14, 8'h04, 8'h34, 8'h24}) begin
            dec_sel = SelRi10;
        end else if (instr[31:21] inside {11'h07B, 11'h078}) begin
            dec_sel = SelRi7;
        end else begin
            dec_has = 1'b0;
        end
    end

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid_q && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_instr_q <= '0;
            main_sel_q   <= SelRi7;
            main_has_q   <= 1'b0;
            main_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_sel_q   <= SelRi7;
            skid_has_q   <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!main_valid_q || out_fire) begin
            // Main is free this edge; the skid entry is older than any new word so it goes first.
            if (skid_valid_q) begin
                main_instr_q <= skid_instr_q;
                main_sel_q   <= skid_sel_q;
                main_has_q   <= skid_has_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                main_valid_q <= in_fire;
                if (in_fire) begin
                    main_instr_q <= instr;
                    main_sel_q   <= dec_sel;
                    main_has_q   <= dec_has;
                end
            end
        end else if (in_fire) begin
            skid_instr_q <= instr;
            skid_sel_q   <= dec_sel;
            skid_has_q   <= dec_has;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid = main_valid_q;
    assign imm7      = main_instr_q[20:14];
    assign imm10     = main_instr_q[23:14];
    assign imm16     = main_instr_q[22:7];
    assign imm18     = main_instr_q[24:7];
    assign imm_sel   = main_sel_q;
    assign has_imm   = main_has_q;
    assign ra        = main_instr_q[13:7];
    assign rt        = main_instr_q[6:0];
    assign op11      = main_instr_q[31:21];

`ifdef IMM_UNSUP_CNT_EN
    logic [CNT_W-1:0] unsup_cnt_q;

    // Flushed words are never accepted, so they are not counted; flush leaves the count intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unsup_cnt_q <= '0;
        end else if (in_fire && !flush && !dec_has && (unsup_cnt_q != '1)) begin
            unsup_cnt_q <= unsup_cnt_q + 1'b1;
        end
    end

    assign unsup_cnt = unsup_cnt_q;
`endif

endmodule
